// File: rtl/pipe_ctrl_seq_if.sv
// rtl/pipe_ctrl_seq_if.sv - pipeline/controller signal bundle for the sequencing controller
interface pipe_ctrl_seq_if;
    logic        stallreq_id_i;
    logic        stallreq_ex_i;
    logic        stallreq_mem_i;
    logic [31:0] excepttype_i;
    logic [31:0] cp0_epc_i;
    logic        clr_cnt_i;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic [31:0] stall_cycles_o;
    logic        stall_timeout_o;

    modport master (
        output stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
        output excepttype_i, cp0_epc_i, clr_cnt_i,
        input  stall, flush, new_pc, stall_cycles_o, stall_timeout_o
    );

    modport slave (
        input  stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
        input  excepttype_i, cp0_epc_i, clr_cnt_i,
        output stall, flush, new_pc, stall_cycles_o, stall_timeout_o
    );
endinterface

// File: rtl/pipe_ctrl_seq.sv
// rtl/pipe_ctrl_seq.sv - 5-stage pipeline stall/flush sequencer with stall statistics
module pipe_ctrl_seq #(
    parameter logic [31:0] EXC_VECTOR  = 32'h0000_0020,
    parameter logic [31:0] ERET_TYPE   = 32'h0000_000e,
    parameter logic [15:0] STALL_LIMIT = 16'd1024
) (
    input  logic            clk,
    input  logic            rst,
    pipe_ctrl_seq_if.slave  bus
);
    typedef enum logic [1:0] {S_RUN, S_FLUSH, S_RECOVER} state_t;

    state_t      r_state;
    logic        r_flush;
    logic [31:0] r_new_pc;
    logic [31:0] r_stall_cycles;
    logic [15:0] r_run_cnt;
    logic        r_timeout;

    logic        w_exc;
    logic        w_stalled;
    logic [5:0]  w_stall;

    // Stall requests only act in RUN; FLUSH/RECOVER drive an empty vector.
    always_comb begin
        w_exc   = |bus.excepttype_i;
        w_stall = 6'b000000;
        if (rst && r_state == S_RUN) begin
            if (w_exc)                   w_stall = 6'b111111;
            else if (bus.stallreq_mem_i) w_stall = 6'b011111;
            else if (bus.stallreq_ex_i)  w_stall = 6'b001111;
            else if (bus.stallreq_id_i)  w_stall = 6'b000111;
        end
        w_stalled = |w_stall;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_RUN;
            r_flush  <= 1'b0;
            r_new_pc <= 32'h0;
        end else begin
            case (r_state)
                S_RUN: begin
                    r_flush <= 1'b0;
                    if (w_exc) begin
                        r_state  <= S_FLUSH;
                        r_flush  <= 1'b1;
                        r_new_pc <= (bus.excepttype_i == ERET_TYPE) ? bus.cp0_epc_i : EXC_VECTOR;
                    end
                end
                S_FLUSH: begin
                    r_state <= S_RECOVER;
                    r_flush <= 1'b0;
                end
                S_RECOVER: begin
                    r_state <= S_RUN;
                    r_flush <= 1'b0;
                end
                default: begin
                    r_state <= S_RUN;
                    r_flush <= 1'b0;
                end
            endcase
        end
    end

    // Run counter saturates at the limit; the timeout flag latches on the edge it gets there.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cycles <= 32'h0;
            r_run_cnt      <= 16'h0;
            r_timeout      <= 1'b0;
        end else if (bus.clr_cnt_i) begin
            r_stall_cycles <= 32'h0;
            r_run_cnt      <= 16'h0;
            r_timeout      <= 1'b0;
        end else if (w_stalled) begin
            r_stall_cycles <= r_stall_cycles + 32'h1;
            if (r_run_cnt != STALL_LIMIT)
                r_run_cnt <= r_run_cnt + 16'h1;
            if (r_run_cnt >= STALL_LIMIT - 16'h1)
                r_timeout <= 1'b1;
        end else begin
            r_run_cnt <= 16'h0;
        end
    end

    assign bus.stall           = w_stall;
    assign bus.flush           = r_flush;
    assign bus.new_pc          = r_new_pc;
    assign bus.stall_cycles_o  = r_stall_cycles;
    assign bus.stall_timeout_o = r_timeout;
endmodule

// File: tb/tb_pipe_ctrl_seq.sv
// tb/tb_pipe_ctrl_seq.sv - self-checking bench for pipe_ctrl_seq
module tb_pipe_ctrl_seq;
    logic clk = 1'b0;
    logic rst = 1'b0;

    pipe_ctrl_seq_if bus ();

    pipe_ctrl_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] pc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_cycles = 32'h0;

    task automatic drive(input logic id, input logic ex, input logic mem,
                         input logic [31:0] exc, input logic [31:0] epc, input logic clr);
        bus.stallreq_id_i  = id;
        bus.stallreq_ex_i  = ex;
        bus.stallreq_mem_i = mem;
        bus.excepttype_i   = exc;
        bus.cp0_epc_i      = epc;
        bus.clr_cnt_i      = clr;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        drive(0, 0, 0, 32'h0, 32'h0, 0);
        repeat (3) @(negedge clk);
        #1;
        n_cmp++; if (bus.stall !== 6'h0) begin n_bad++; $display("FAIL reset_stall got=%b exp=000000", bus.stall); end
        n_cmp++; if (bus.flush !== 1'b0) begin n_bad++; $display("FAIL reset_flush got=%b exp=0", bus.flush); end
        n_cmp++; if (bus.new_pc !== 32'h0) begin n_bad++; $display("FAIL reset_new_pc got=%h exp=0", bus.new_pc); end
        n_cmp++; if (bus.stall_cycles_o !== 32'h0) begin n_bad++; $display("FAIL reset_cycles got=%0d exp=0", bus.stall_cycles_o); end
        n_cmp++; if (bus.stall_timeout_o !== 1'b0) begin n_bad++; $display("FAIL reset_timeout got=%b exp=0", bus.stall_timeout_o); end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            n_cmp++;
            if (bus.stall !== 6'h0 || bus.flush !== 1'b0 || bus.stall_cycles_o !== 32'h0) begin
                n_bad++;
                $display("FAIL idle_after_reset cyc=%0d got stall=%b flush=%b cycles=%0d exp 000000/0/0",
                         i, bus.stall, bus.flush, bus.stall_cycles_o);
            end
        end
    endtask

    task automatic test_stall_priority;
        logic       t_id[11]  = '{1, 1, 1, 0, 0, 1, 0, 1, 1, 0, 0};
        logic       t_ex[11]  = '{0, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0};
        logic       t_mem[11] = '{1, 1, 1, 0, 0, 0, 1, 0, 1, 1, 0};
        logic [5:0] t_exp[11] = '{6'h1F, 6'h1F, 6'h1F, 6'h0F, 6'h0F, 6'h07,
                                  6'h1F, 6'h0F, 6'h1F, 6'h1F, 6'h00};
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            drive(t_id[i], t_ex[i], t_mem[i], 32'h0, 32'h0, 0);
            exp_q.push_back('{stall: t_exp[i], flush: 1'b0, pc: 32'h0});
            #1;
            e = exp_q.pop_front();
            n_cmp++;
            if (bus.stall !== e.stall || bus.flush !== e.flush || bus.new_pc !== e.pc) begin
                n_bad++;
                $display("FAIL stall_prio[%0d] got stall=%b flush=%b pc=%h exp stall=%b flush=%b pc=%h",
                         i, bus.stall, bus.flush, bus.new_pc, e.stall, e.flush, e.pc);
            end
            n_cmp++;
            if (bus.stall_cycles_o !== exp_cycles) begin
                n_bad++;
                $display("FAIL stall_cycles[%0d] got=%0d exp=%0d", i, bus.stall_cycles_o, exp_cycles);
            end
            if (i == 3) begin
                n_cmp++;
                if (bus.stall_timeout_o !== 1'b0) begin n_bad++; $display("FAIL prio_timeout got=%b exp=0", bus.stall_timeout_o); end
            end
            if (e.stall != 6'h0) exp_cycles++;
        end
    endtask

    task automatic test_exception;
        logic [31:0] t_exc[15] = '{32'h8, 32'h0, 32'h0, 32'h0, 32'he, 32'h0, 32'h0, 32'h0,
                                   32'h8, 32'h8, 32'h8, 32'h8, 32'h0, 32'h0, 32'h0};
        logic [31:0] t_epc[15] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h1234, 32'h0, 32'h0, 32'h0,
                                   32'h5555, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        logic        t_ex[15]  = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        logic        t_mem[15] = '{0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0};
        logic [5:0]  t_stl[15] = '{6'h3F, 6'h00, 6'h00, 6'h0F, 6'h3F, 6'h00, 6'h00, 6'h00,
                                   6'h3F, 6'h00, 6'h00, 6'h3F, 6'h00, 6'h00, 6'h00};
        logic        t_fl[15]  = '{0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1, 0, 0};
        logic [31:0] t_pc[15]  = '{32'h0, 32'h20, 32'h20, 32'h20, 32'h20, 32'h1234, 32'h1234, 32'h1234,
                                   32'h1234, 32'h20, 32'h20, 32'h20, 32'h20, 32'h20, 32'h20};
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            drive(0, t_ex[i], t_mem[i], t_exc[i], t_epc[i], 0);
            exp_q.push_back('{stall: t_stl[i], flush: t_fl[i], pc: t_pc[i]});
            #1;
            e = exp_q.pop_front();
            n_cmp++;
            if (bus.stall !== e.stall || bus.flush !== e.flush || bus.new_pc !== e.pc) begin
                n_bad++;
                $display("FAIL exc_seq[%0d] got stall=%b flush=%b pc=%h exp stall=%b flush=%b pc=%h",
                         i, bus.stall, bus.flush, bus.new_pc, e.stall, e.flush, e.pc);
            end
            n_cmp++;
            if (bus.stall_cycles_o !== exp_cycles) begin
                n_bad++;
                $display("FAIL exc_cycles[%0d] got=%0d exp=%0d", i, bus.stall_cycles_o, exp_cycles);
            end
            if (e.stall != 6'h0) exp_cycles++;
        end
    endtask

    task automatic test_timeout;
        @(negedge clk);
        drive(0, 0, 0, 32'h0, 32'h0, 1);
        @(negedge clk);
        drive(0, 1, 0, 32'h0, 32'h0, 1);
        #1;
        n_cmp++; if (bus.stall_cycles_o !== 32'h0) begin n_bad++; $display("FAIL clr_cycles got=%0d exp=0", bus.stall_cycles_o); end
        @(negedge clk);
        drive(0, 1, 0, 32'h0, 32'h0, 0);
        #1;
        n_cmp++; if (bus.stall_cycles_o !== 32'h0) begin n_bad++; $display("FAIL clr_override got=%0d exp=0", bus.stall_cycles_o); end
        for (int i = 1; i <= 1030; i++) begin
            @(negedge clk);
            #1;
            if (i == 1023 || i == 1024 || i == 1030) begin
                n_cmp++;
                if (bus.stall_timeout_o !== (i >= 1024)) begin
                    n_bad++;
                    $display("FAIL timeout_at_%0d got=%b exp=%b", i, bus.stall_timeout_o, (i >= 1024));
                end
                n_cmp++;
                if (bus.stall_cycles_o !== 32'(i)) begin
                    n_bad++;
                    $display("FAIL long_cycles_at_%0d got=%0d exp=%0d", i, bus.stall_cycles_o, i);
                end
            end
        end
        drive(0, 0, 0, 32'h0, 32'h0, 0);
        repeat (3) @(negedge clk);
        #1;
        n_cmp++; if (bus.stall_timeout_o !== 1'b1) begin n_bad++; $display("FAIL timeout_sticky got=%b exp=1", bus.stall_timeout_o); end
        n_cmp++; if (bus.stall_cycles_o !== 32'd1030) begin n_bad++; $display("FAIL cycles_hold got=%0d exp=1030", bus.stall_cycles_o); end
        @(negedge clk);
        drive(0, 0, 0, 32'h0, 32'h0, 1);
        @(negedge clk);
        drive(0, 0, 0, 32'h0, 32'h0, 0);
        #1;
        n_cmp++; if (bus.stall_timeout_o !== 1'b0) begin n_bad++; $display("FAIL timeout_clr got=%b exp=0", bus.stall_timeout_o); end
        n_cmp++; if (bus.stall_cycles_o !== 32'h0) begin n_bad++; $display("FAIL cycles_clr got=%0d exp=0", bus.stall_cycles_o); end
    endtask

    task automatic test_reset_mid_flush;
        @(negedge clk);
        drive(0, 0, 0, 32'h8, 32'h0, 0);
        @(negedge clk);
        drive(0, 0, 0, 32'h0, 32'h0, 0);
        #1;
        n_cmp++; if (bus.flush !== 1'b1) begin n_bad++; $display("FAIL pre_reset_flush got=%b exp=1", bus.flush); end
        #2 rst = 1'b0;
        #1;
        n_cmp++; if (bus.flush !== 1'b0) begin n_bad++; $display("FAIL async_flush got=%b exp=0", bus.flush); end
        n_cmp++; if (bus.new_pc !== 32'h0) begin n_bad++; $display("FAIL async_new_pc got=%h exp=0", bus.new_pc); end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            n_cmp++;
            if (bus.flush !== 1'b0 || bus.stall !== 6'h0) begin
                n_bad++;
                $display("FAIL post_reset[%0d] got flush=%b stall=%b exp 0/000000", i, bus.flush, bus.stall);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stall_priority();
        test_exception();
        test_timeout();
        test_reset_mid_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
